axi_lite_cfg_master: RTL and testbench
======================================

# axi_lite_cfg_master

AXI4-Lite initiator that drives the configuration register port of the network top level. It takes single-word commands (write or read, address, data) from a simple valid/ready command port. Each command becomes one AXI4-Lite transaction, and the completion response is returned on a response port. The host-side sequencer uses it to load layer and neuron selects, weights and biases, to issue soft reset, and to read back results.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32: AXI data width; also the width of cmd_wdata and rsp_rdata.
- C_M_AXI_ADDR_WIDTH, 5: AXI address width; also the width of cmd_addr.

Ports:
- s_axi_aclk  in  1  single clock; all logic on its rising edge.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- err_sticky  out  1  set by any non-OKAY response.
- err_clr  in  1  clears err_sticky.
- busy  out  1  a transaction is in flight.
- txn_count  out  16  count of completed transactions.
- m_axi_awaddr/awprot/awvalid  out  ADDR/3/1  write address channel; awprot is always 3'b000.
- m_axi_awready  in  1.
- m_axi_wdata/wstrb/wvalid  out  DATA/DATA/8/1  write data channel; wstrb is always all ones.
- m_axi_wready  in  1.
- m_axi_bresp/bvalid  in  2/1; m_axi_bready  out  1.
- m_axi_araddr/arprot/arvalid  out  ADDR/3/1  read address channel; arprot is always 3'b000.
- m_axi_arready  in  1.
- m_axi_rdata/rresp/rvalid  in  DATA/2/1; m_axi_rready  out  1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. At most one transaction is outstanding.
- Reset values: every output is 0, including cmd_ready, all valid and ready signals, txn_count and err_sticky. The state is IDLE.
- cmd_ready is registered. It rises in the first cycle after reset deasserts. It falls on command acceptance. It rises again in the same cycle that rsp_valid is high.
- Acceptance happens on the edge where cmd_valid & cmd_ready are both high. At that edge the block captures cmd_addr and cmd_wdata, and moves to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
- WR_REQ:
  - awvalid and wvalid rise together, registered.
  - Each drops on the edge after its own handshake, and the two may complete in either order.
  - Once both channels have handshaken, move to WR_RESP.
  - Address and data must stay stable while the corresponding valid is high.
- WR_RESP:
  - bready is high throughout the state.
  - On bvalid & bready, capture bresp, set rsp_rdata to 0, and return to IDLE.
- RD_REQ:
  - arvalid is high until the arready handshake, then move to RD_RESP.
- RD_RESP:
  - rready is high throughout the state.
  - On rvalid & rready, capture rdata and rresp, and return to IDLE.
- Completion: rsp_valid is high for exactly one cycle after the response handshake. rsp_rdata and rsp_resp hold their values until the next completion.
- txn_count increments at each completion and wraps from 0xFFFF to 0x0000.
- err_sticky:
  - Set when the completing response is not equal to 2'b00.
  - Cleared by err_clr.
  - Set wins when a set and err_clr happen in the same cycle.
- busy is 1 from the cycle after acceptance until the cycle rsp_valid is high, where it returns to 0.
- cmd_valid while cmd_ready=0 is ignored; the command is not captured.
- Reset asserted mid-transaction: all AXI valid and ready outputs drop immediately and asynchronously, and no rsp_valid is produced. After release the block restarts clean from IDLE.

## Timing
- Write, best case (awready=wready=1, bvalid returned in the cycle after the AW/W handshake), command accepted at edge N:
  - awvalid and wvalid are high in cycle N+1.
  - bready is high in cycle N+2.
  - rsp_valid and cmd_ready are high in cycle N+3.
- Read, best case: arvalid high in N+1, rready high in N+2, rsp_valid in N+3.
- Minimum command-to-command spacing is therefore 3 cycles.
- Back-pressure from any ready signal extends the current state by one cycle per stalled cycle; the block has no timeout.
- No combinational path exists from any AXI input to any AXI output.

## Test plan
- Write, slave always ready: cmd write addr 0x04, data 0xDEADBEEF. Required: awaddr=0x04, wdata=0xDEADBEEF and wstrb=0xF in one cycle; rsp_valid 3 cycles after acceptance with rsp_resp=0 and rsp_rdata=0; txn_count=1.
- Split handshake: wready held low 4 cycles after awready. Required: awvalid drops after its handshake; wvalid stays high with stable data until wready; exactly one response, with rsp_valid 7 cycles after acceptance.
- Read: cmd read addr 0x1C; slave returns rdata 0x00000007 after 2 wait cycles. Required: rsp_rdata=0x7, rsp_resp=0, busy low in the rsp_valid cycle.
- Error handling: a read returns rresp=2'b10. Required: rsp_resp=2, err_sticky=1. Then err_clr asserted in the same cycle as a second error completion: err_sticky stays 1. err_clr alone afterwards: err_sticky goes to 0.
- Reset mid-write: assert aresetn low while awvalid=1. Required: all outputs 0 in the same cycle; no rsp_valid; after release cmd_ready=1 in the first clocked cycle and a new write completes normally.
- Counter wrap: preload txn_count to 0xFFFF via 65535 writes, or force it in the bench, then complete one transaction. Required: txn_count=0x0000.

Source files
------------

// File: rtl/axi_lite_cfg_master_if.sv
// AXI4-Lite bus bundle between the config master and the network register port.
// The master modport is the initiator side; slave is the register block side.
interface axi_lite_cfg_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [2:0]          m_axi_arprot;
  logic                m_axi_arvalid;
  logic                m_axi_arready;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_rvalid;
  logic                m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
    input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid, input m_axi_arready,
    input m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
  );

  modport slave (
    input m_axi_awaddr, m_axi_awprot, m_axi_awvalid, output m_axi_awready,
    input m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
    input m_axi_araddr, m_axi_arprot, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
  );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction,
// one completion pulse out. Every output comes straight from a flop.
module axi_lite_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          err_sticky,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [15:0]                   txn_count,
  axi_lite_cfg_master_if.master         m_axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e                        state_q;
  logic                          cmd_ready_q, busy_q, err_q, rsp_valid_q;
  logic                          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;
  logic [1:0]                    rsp_resp_q;
  logic [15:0]                   txn_count_q, txn_count_d;

  logic                          done;
  logic [1:0]                    resp_in;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_in;

  // Response handshake is qualified by state, so bready/rready need not be re-read.
  assign done     = (state_q == WR_RESP && m_axi.m_axi_bvalid) ||
                    (state_q == RD_RESP && m_axi.m_axi_rvalid);
  assign resp_in  = (state_q == RD_RESP) ? m_axi.m_axi_rresp : m_axi.m_axi_bresp;
  assign rdata_in = (state_q == RD_RESP) ? m_axi.m_axi_rdata : '0;
  assign txn_count_d = txn_count_q + 16'd1;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      txn_count_q <= 16'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once neither is still pending.
          if (m_axi.m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi.m_axi_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi.m_axi_awready) && (!wvalid_q || m_axi.m_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        RD_REQ: begin
          if (m_axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        WR_RESP, RD_RESP: ;
        default: state_q <= IDLE;
      endcase
      if (done) begin
        bready_q    <= 1'b0;
        rready_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= resp_in;
        rsp_rdata_q <= rdata_in;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        txn_count_q <= txn_count_d;
        if (resp_in != 2'b00) err_q <= 1'b1;  // overrides err_clr above
        state_q     <= IDLE;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_resp   = rsp_resp_q;
  assign err_sticky = err_q;
  assign busy       = busy_q;
  assign txn_count  = txn_count_q;

  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wstrb   = '1;
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = bready_q;
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arprot  = 3'b000;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Randomized bench for axi_lite_cfg_master: a configurable-wait AXI slave,
// a scoreboard of expected completions and a decoupled response monitor.
module tb_axi_lite_cfg_master;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, err_sticky, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [15:0]   txn_count;

  axi_lite_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) ax();

  axi_lite_cfg_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy), .txn_count(txn_count),
    .m_axi(ax.master)
  );

  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] cnt;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  // Reference state: what the register port should report after each completion.
  logic [15:0] model_cnt = 16'd0;
  logic        model_err = 1'b0;

  // Slave configuration for the transaction in flight.
  bit          sl_wr;
  logic [AW-1:0] sl_addr;
  logic [DW-1:0] sl_wdata, sl_rdata;
  logic [1:0]  sl_resp;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_hs, w_hs, ar_hs;

  // Slave: ready/valid decided on the falling edge, handshake lands on the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      ax.m_axi_awready = 1'b0; ax.m_axi_wready = 1'b0; ax.m_axi_arready = 1'b0;
      ax.m_axi_bvalid = 1'b0;  ax.m_axi_rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      ax.m_axi_awready = 1'b0;
      if (ax.m_axi_awvalid) begin
        chk("aw_once", 32'(aw_hs), 0);
        chk("aw_is_write", 32'(sl_wr), 1);
        chk("awaddr", 32'(ax.m_axi_awaddr), 32'(sl_addr));
        chk("awprot", 32'(ax.m_axi_awprot), 0);
        if (aw_cnt >= aw_wait) begin ax.m_axi_awready = 1'b1; aw_hs = 1'b1; end
        aw_cnt++;
      end else aw_cnt = 0;

      ax.m_axi_wready = 1'b0;
      if (ax.m_axi_wvalid) begin
        chk("w_once", 32'(w_hs), 0);
        chk("wdata", ax.m_axi_wdata, sl_wdata);
        chk("wstrb", 32'(ax.m_axi_wstrb), 32'hF);
        if (w_cnt >= w_wait) begin ax.m_axi_wready = 1'b1; w_hs = 1'b1; end
        w_cnt++;
      end else w_cnt = 0;

      ax.m_axi_arready = 1'b0;
      if (ax.m_axi_arvalid) begin
        chk("ar_once", 32'(ar_hs), 0);
        chk("ar_is_read", 32'(sl_wr), 0);
        chk("araddr", 32'(ax.m_axi_araddr), 32'(sl_addr));
        chk("arprot", 32'(ax.m_axi_arprot), 0);
        if (ar_cnt >= ar_wait) begin ax.m_axi_arready = 1'b1; ar_hs = 1'b1; end
        ar_cnt++;
      end else ar_cnt = 0;

      ax.m_axi_bvalid = 1'b0;
      ax.m_axi_bresp  = 2'($urandom);
      if (ax.m_axi_bready) begin
        if (b_cnt >= b_wait) begin ax.m_axi_bvalid = 1'b1; ax.m_axi_bresp = sl_resp; end
        b_cnt++;
      end else b_cnt = 0;

      ax.m_axi_rvalid = 1'b0;
      ax.m_axi_rresp  = 2'($urandom);
      ax.m_axi_rdata  = $urandom;
      if (ax.m_axi_rready) begin
        if (r_cnt >= r_wait) begin
          ax.m_axi_rvalid = 1'b1; ax.m_axi_rresp = sl_resp; ax.m_axi_rdata = sl_rdata;
        end
        r_cnt++;
      end else r_cnt = 0;
    end
  end

  // Monitor: every rsp_valid cycle consumes exactly one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        chk("txn_count", 32'(txn_count), 32'(e.cnt));
        chk("err_sticky", 32'(err_sticky), 32'(e.err));
        chk("busy_at_rsp", 32'(busy), 0);
        chk("cmd_ready_at_rsp", 32'(cmd_ready), 1);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic arm_slave(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int w0, input int w1, input int w2,
                           input logic [1:0] resp, input logic [DW-1:0] rd);
    sl_wr = wr; sl_addr = addr; sl_wdata = wd; sl_resp = resp; sl_rdata = rd;
    aw_wait = w0; w_wait = w1; b_wait = w2; ar_wait = w0; r_wait = w2;
    aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0;
  endtask

  // Write: w0/w1 = AW/W ready delay, w2 = B delay. Read: w0 = AR delay, w2 = R delay.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int w0, input int w1, input int w2,
                        input logic [1:0] resp, input logic [DW-1:0] rd,
                        input bit clr, input bit junk);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    if (!cmd_ready) return;
    arm_slave(wr, addr, wd, w0, w1, w2, resp, rd);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; err_clr = clr;
    e.acc = cyc;
    @(negedge clk);
    chk("busy_inflight", 32'(busy), 1);
    model_cnt = model_cnt + 16'd1;
    model_err = (resp != 2'b00) || (model_err && !clr);
    e.rdata = wr ? 32'd0 : rd;
    e.resp  = resp;
    e.cnt   = model_cnt;
    e.err   = model_err;
    e.lat   = wr ? 3 + ((w0 > w1) ? w0 : w1) + w2 : 3 + w0 + w2;
    sb.push_back(e);
    if (junk) begin
      cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    end else cmd_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); cmd_valid = 1'b0; t++; end while (!rsp_valid && t < 1000);
    chk("rsp_arrived", 32'(rsp_valid), 1);
    err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_txn_count"}, 32'(txn_count), 0);
    chk({tag, "_err_sticky"}, 32'(err_sticky), 0);
    chk({tag, "_awvalid"}, 32'(ax.m_axi_awvalid), 0);
    chk({tag, "_wvalid"}, 32'(ax.m_axi_wvalid), 0);
    chk({tag, "_bready"}, 32'(ax.m_axi_bready), 0);
    chk({tag, "_arvalid"}, 32'(ax.m_axi_arvalid), 0);
    chk({tag, "_rready"}, 32'(ax.m_axi_rready), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ax.m_axi_awready = 1'b0; ax.m_axi_wready = 1'b0; ax.m_axi_arready = 1'b0;
    ax.m_axi_bvalid = 1'b0; ax.m_axi_bresp = 2'b00;
    ax.m_axi_rvalid = 1'b0; ax.m_axi_rresp = 2'b00; ax.m_axi_rdata = '0;
    arm_slave(1'b0, '0, '0, 0, 0, 0, 2'b00, '0);

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 1);

    // Directed: best-case write, split W handshake, waited read.
    do_txn(1'b1, 5'h04, 32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h1234_5678, 1'b0, 1'b0);
    do_txn(1'b1, 5'h08, 32'hCAFE_0001, 0, 4, 0, 2'b00, 32'h0, 1'b0, 1'b1);
    do_txn(1'b0, 5'h1C, 32'hFFFF_FFFF, 0, 0, 2, 2'b00, 32'h0000_0007, 1'b0, 1'b0);

    // Error stickiness: set, set+clear same cycle, then clear alone.
    do_txn(1'b0, 5'h10, 32'h0, 1, 0, 0, 2'b10, 32'hBAD0_BAD0, 1'b0, 1'b0);
    do_txn(1'b1, 5'h14, 32'h5555_AAAA, 0, 1, 1, 2'b10, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_held", 32'(err_sticky), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    chk("err_cleared", 32'(err_sticky), 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      do_txn(1'($urandom), AW'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             r, $urandom, ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Reset in the middle of a write that the slave never accepts.
    @(negedge clk);
    arm_slave(1'b1, 5'h0C, 32'h0BAD_F00D, 1000, 1000, 0, 2'b00, '0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h0C; cmd_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("awvalid_before_reset", 32'(ax.m_axi_awvalid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    model_cnt = 16'd0;
    model_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_midreset", 32'(cmd_ready), 1);
    do_txn(1'b1, 5'h00, 32'h0000_0001, 0, 0, 0, 2'b00, '0, 1'b0, 1'b0);

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count_q;
    @(negedge clk);
    model_cnt = 16'hFFFF;
    chk("txn_preload", 32'(txn_count), 32'h0000_FFFF);
    do_txn(1'b0, 5'h18, 32'h0, 0, 0, 0, 2'b00, 32'hA5A5_5A5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("txn_wrapped", 32'(txn_count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
